nexi_uart_tx: RTL and testbench

UART transmitter for the minimal UART module; the transmit-side counterpart of the minimal receiver, running on the same 16x bit-rate clock. It accepts bytes from a master through a four-phase req/ack handshake and buffers one byte in a holding register. It then serialises each byte on `tx_pin` as start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits, with each bit lasting 16 clock cycles.

---
 rtl/nexi_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_nexi_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nexi_uart_tx.sv
// nexi_uart_tx: 16x-clocked UART transmitter, req/ack fed holding register.
// Define NEXI_UART_TX_PARITY_EN to insert an even parity bit after the data.
module nexi_uart_tx #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk_16x_bps,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [7:0] data,
    output logic       wr_ack,
    output logic       tx_pin,
    output logic       tx_busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef NEXI_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic       req_s1_q, req_s2_q;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       ack_q, ack_d;
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       bit_end, load;
`ifdef NEXI_UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ack_d       = ack_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
`ifdef NEXI_UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        bit_end     = (cnt_q == 4'd0);
        load        = 1'b0;

        unique case (state_q)
            S_IDLE: load = hold_full_q;
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = 4'd15;
                    bcnt_d  = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = 4'd15;
                    if (bcnt_q == 3'd7) begin
`ifdef NEXI_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                        bcnt_d  = 3'd0;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bcnt_d  = bcnt_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef NEXI_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = 4'd15;
                    bcnt_d  = 3'd0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            S_STOP: begin
                if (!bit_end) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (bcnt_q != 3'(STOP_BITS - 1)) begin
                    bcnt_d = bcnt_q + 3'd1;
                    cnt_d  = 4'd15;
                end else if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A queued byte restarts the frame directly, giving gapless output.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = S_START;
            cnt_d       = 4'd15;
`ifdef NEXI_UART_TX_PARITY_EN
            par_d       = ^hold_q;
`endif
        end

        if (req_s2_q && !ack_q && !hold_full_q) begin
            hold_d      = data;
            hold_full_d = 1'b1;
            ack_d       = 1'b1;
        end else if (ack_q && !req_s2_q) begin
            ack_d = 1'b0;
        end
    end

    always_ff @(posedge clk_16x_bps) begin
        if (!rst_n) begin
            req_s1_q    <= 1'b0;
            req_s2_q    <= 1'b0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            ack_q       <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            bcnt_q      <= 3'd0;
            shift_q     <= 8'd0;
            tx_q        <= 1'b1;
`ifdef NEXI_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            req_s1_q    <= wr_req;
            req_s2_q    <= req_s1_q;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ack_q       <= ack_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
`ifdef NEXI_UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign wr_ack  = ack_q;
    assign tx_pin  = tx_q;
    assign tx_busy = (state_q != S_IDLE) | hold_full_q;
endmodule

// File: tb/tb_nexi_uart_tx.sv
// tb_nexi_uart_tx: random req/ack traffic against a queue-of-line-levels model,
// plus literal frame, handshake, back-to-back and reset checks.
module tb_nexi_uart_tx;
    parameter int SB = 1;
`ifdef NEXI_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 9 + P + SB;
    localparam int FL = 16 * NB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] data = 8'h00;
    logic       wr_ack, tx_pin, tx_busy;
    int         nvec = 0;
    int         nerr = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    nexi_uart_tx #(.STOP_BITS(SB)) dut (
        .clk_16x_bps(clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .data       (data),
        .wr_ack     (wr_ack),
        .tx_pin     (tx_pin),
        .tx_busy    (tx_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: the line is a queue of per-cycle levels; a frame is appended
    // when the line runs dry and a byte is held.
    bit       m_s1 = 0, m_s2 = 0, m_ack = 0, m_hf = 0;
    bit       o_s2, o_ack, o_hf;
    bit [7:0] m_hold = 0;
    bit       line[$];

    function automatic void push_lvl(input bit b, input int n);
        for (int i = 0; i < n; i++) line.push_back(b);
    endfunction

    function automatic void push_frame(input bit [7:0] d);
        push_lvl(1'b0, 16);
        for (int i = 0; i < 8; i++) push_lvl(d[i], 16);
        if (P == 1) push_lvl(^d, 16);
        push_lvl(1'b1, 16 * SB);
    endfunction

    always @(posedge clk) begin
        cyc++;
        o_s2 = m_s2; o_ack = m_ack; o_hf = m_hf;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_ack = 0; m_hf = 0;
            line.delete();
        end else begin
            m_s2 = m_s1;
            m_s1 = wr_req;
            if (line.size() > 0) void'(line.pop_front());
            if (line.size() == 0 && o_hf) begin
                push_frame(m_hold);
                m_hf = 0;
            end
            if (o_s2 && !o_ack && !o_hf) begin
                m_hold = data; m_hf = 1; m_ack = 1;
            end else if (o_ack && !o_s2) begin
                m_ack = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("tx_pin", tx_pin, (line.size() > 0) ? line[0] : 1'b1);
            chk("wr_ack", wr_ack, m_ack);
            chk("tx_busy", tx_busy, (line.size() > 0) || m_hf);
        end
    end

    task automatic wait_ack(input logic lvl, input int lim, input string nm);
        int n = 0;
        while (wr_ack !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (wr_ack !== lvl) chk(nm, wr_ack, lvl);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (tx_busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy !== 1'b0) chk("idle_timeout", tx_busy, 0);
    endtask

    // pat[k] is the line level of bit k (start then data LSB first).
    task automatic frame_check(input logic [7:0] d, input logic [8:0] pat, input logic par);
        logic e;
        int   k;
        data = d;
        wr_req = 1'b1;
        wait_ack(1'b1, 10, "ack_rise");
        wr_req = 1'b0;
        @(negedge clk);
        chk("start_lat", tx_pin, 0);
        for (int c = 0; c <= FL; c++) begin
            if (c % 16 == 8) begin
                k = c / 16;
                if (k < 9) e = pat[k];
                else if (P == 1 && k == 9) e = par;
                else e = 1'b1;
                chk("frame_bit", tx_pin, e);
            end
            if (c == FL - 1) chk("busy_end", tx_busy, 1);
            if (c == FL) chk("busy_fall", tx_busy, 0);
            if (c < FL) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int c, ack2, rises;
        logic pb;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_pin, 1);
        chk("rst_ack", wr_ack, 0);
        chk("rst_busy", tx_busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        frame_check(8'h55, 9'h0AA, 1'b0);
        frame_check(8'h01, 9'h002, 1'b1);
        frame_check(8'h03, 9'h006, 1'b0);
        frame_check(8'hFF, 9'h1FE, 1'b0);

        // Reset at cycle 40 of a 0x00 frame.
        data = 8'h00;
        wr_req = 1'b1;
        wait_ack(1'b1, 10, "ack_rise");
        wr_req = 1'b0;
        repeat (41) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx_pin, 1);
        chk("midrst_busy", tx_busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // wr_req held for 200 cycles: one frame only.
        data = 8'hA5;
        wr_req = 1'b1;
        rises = 0;
        pb = tx_busy;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_busy && !pb) rises++;
            pb = tx_busy;
        end
        chk("hs_ack_hold", wr_ack, 1);
        wr_req = 1'b0;
        @(negedge clk);
        chk("hs_ack_f1", wr_ack, 1);
        @(negedge clk);
        chk("hs_ack_f2", wr_ack, 1);
        @(negedge clk);
        chk("hs_ack_f3", wr_ack, 0);
        c = 0;
        while (tx_busy && c < 2 * FL) begin
            @(negedge clk);
            if (tx_busy && !pb) rises++;
            pb = tx_busy;
            c++;
        end
        chk("hs_frames", rises, 1);
        repeat (4) @(negedge clk);

        // Back-to-back 0x0F then 0xF0.
        data = 8'h0F;
        wr_req = 1'b1;
        wait_ack(1'b1, 10, "ack_rise");
        wr_req = 1'b0;
        @(negedge clk);
        c = 0;
        chk("b2b_start", tx_pin, 0);
        while (wr_ack && c < 20) begin
            @(negedge clk);
            c++;
        end
        data = 8'hF0;
        wr_req = 1'b1;
        ack2 = -1;
        while (c < FL) begin
            @(negedge clk);
            c++;
            if (wr_ack && ack2 < 0) begin
                ack2 = c;
                wr_req = 1'b0;
            end
            if (c == FL - 1) chk("b2b_stop", tx_pin, 1);
            if (c == FL) chk("b2b_start2", tx_pin, 0);
        end
        wr_req = 1'b0;
        chk("b2b_ack_in_frame", (ack2 >= 0 && ack2 < FL), 1);
        wait_idle(2 * FL);
        repeat (4) @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            data = 8'($urandom);
            wr_req = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 150)) @(negedge clk);
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst_n = 1'b1;
            end
            wait_ack(1'b1, 2 * FL + 20, "rnd_ack");
            repeat ($urandom_range(0, 5)) @(negedge clk);
            wr_req = 1'b0;
            wait_ack(1'b0, 10, "rnd_rel");
        end
        wait_idle(2 * FL + 50);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
